c1541_sd_arbiter: RTL and testbench

Sector-level arbiter sharing one host SD block channel (lba/rd/wr/ack plus 512-byte buffer port) among several `c1541_track`-style requesters, e.g. multiple drives. It sits between the requesters and the host I/O block, runs entirely in `sd_clk`, and grants one sector transfer at a time in round-robin order. It latches the winner's LBA and routes buffer traffic only to the granted requester. It also recovers from lost or stale host acks.

---
 rtl/c1541_sd_pkg.sv | 24 ++
 rtl/c1541_rr_pick.sv | 42 ++++
 rtl/c1541_sd_arbiter.sv | 156 +++++++++++++++
 tb/tb_c1541_sd_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1541_sd_pkg.sv
// -----------------------------------------------------------------------------
// c1541_sd_pkg
// Shared types and constants for the SD sector arbiter.
//   state_e   : arbiter FSM states (2 bits)
//   op_e      : latched operation of the current grant
//   TIMEOUT_W : width of the ISSUE-state timeout counter
// -----------------------------------------------------------------------------
package c1541_sd_pkg;

   localparam int TIMEOUT_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_XFER  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

endpackage

// File: rtl/c1541_rr_pick.sv
// -----------------------------------------------------------------------------
// c1541_rr_pick
// Combinational round-robin priority picker. The search starts one past the
// previously served requester and wraps modulo NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   last  in  IDX_W    index of the requester served last
//   valid out 1        at least one request is set
//   idx   out IDX_W    index of the winning requester
// -----------------------------------------------------------------------------
module c1541_rr_pick
   import c1541_sd_pkg::*;
#(
   parameter int NUM_REQ = 2,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W-1:0] cand;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      // Walk from farthest to nearest so the nearest hit is the last write
      // and therefore wins.
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = IDX_W'((int'(last) + i) % NUM_REQ);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// -----------------------------------------------------------------------------
// c1541_sd_arbiter
// Shares one host SD sector channel among NUM_REQ requesters, one sector
// transfer at a time in round-robin order. Latches the winner's LBA and
// operation at grant, routes buffer traffic only to the granted requester,
// times out lost acks and absorbs stale acks in DRAIN.
// Ports:
//   sd_clk, reset      clock; synchronous active-high reset
//   req_lba/rd/wr      per-requester sector address and request levels
//   req_ack            sd_ack forwarded to the granted requester in XFER
//   req_err            one-cycle pulse when a requester's issue times out
//   req_buff_wr        sd_buff_wr forwarded to the granted requester in XFER
//   req_buff_din       per-requester write-back data
//   sd_lba/rd/wr       host request (LBA latched at grant, strobes are levels)
//   sd_drive           index of the granted requester
//   sd_ack, sd_buff_wr host acknowledge and buffer write strobe
//   sd_buff_din        write-back data of the granted requester, 0 otherwise
//   busy               FSM is not idle
// -----------------------------------------------------------------------------
module c1541_sd_arbiter
   import c1541_sd_pkg::*;
#(
   parameter int          NUM_REQ = 2,
   parameter int unsigned TIMEOUT = 24'hFFFFFF,
   localparam int         IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      sd_clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0][31:0]  req_lba,
   input  logic [NUM_REQ-1:0]        req_rd,
   input  logic [NUM_REQ-1:0]        req_wr,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [NUM_REQ-1:0]        req_err,
   output logic [NUM_REQ-1:0]        req_buff_wr,
   input  logic [NUM_REQ-1:0][7:0]   req_buff_din,
   output logic [31:0]               sd_lba,
   output logic                      sd_rd,
   output logic                      sd_wr,
   output logic [IDX_W-1:0]          sd_drive,
   input  logic                      sd_ack,
   input  logic                      sd_buff_wr,
   output logic [7:0]                sd_buff_din,
   output logic                      busy
);

   localparam logic [TIMEOUT_W-1:0] TMO_LIM = TIMEOUT_W'(TIMEOUT);
   localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

   state_e                 state_q, state_d;
   op_e                    op_q, op_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [IDX_W-1:0]       drive_q, drive_d;
   logic [31:0]            lba_q, lba_d;
   logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
   logic [NUM_REQ-1:0]     err_q, err_d;

   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;

   c1541_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (req_rd | req_wr),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      last_d  = last_q;
      drive_d = drive_q;
      lba_d   = lba_q;
      tmo_d   = tmo_q;
      err_d   = '0;

      case (state_q)
         ST_IDLE: begin
            // An ack already high here belongs to nobody (timeout or reset).
            if (sd_ack) begin
               state_d = ST_DRAIN;
            end else if (pick_valid) begin
               state_d = ST_ISSUE;
               drive_d = pick_idx;
               lba_d   = req_lba[pick_idx];
               op_d    = req_wr[pick_idx] ? OP_WR : OP_RD;
               tmo_d   = '0;
            end
         end
         ST_ISSUE: begin
            if (sd_ack) begin
               state_d = ST_XFER;
            end else if ((TIMEOUT != 0) && (tmo_q == TMO_LIM)) begin
               state_d        = ST_IDLE;
               err_d[drive_q] = 1'b1;
               last_d         = drive_q;
            end else if (tmo_q != TMO_MAX) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_XFER: begin
            if (!sd_ack) begin
               state_d = ST_IDLE;
               last_d  = drive_q;
            end
         end
         ST_DRAIN: begin
            if (!sd_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge.
   always_ff @(posedge sd_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_RD;
         last_q  <= IDX_W'(NUM_REQ - 1);
         drive_q <= '0;
         lba_q   <= '0;
         tmo_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         last_q  <= last_d;
         drive_q <= drive_d;
         lba_q   <= lba_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   // Buffer routing is combinational so host data reaches the requester
   // with no added latency; only XFER forwards anything.
   always_comb begin
      req_ack     = '0;
      req_buff_wr = '0;
      sd_buff_din = '0;
      if (state_q == ST_XFER) begin
         req_ack[drive_q]     = sd_ack;
         req_buff_wr[drive_q] = sd_buff_wr;
         sd_buff_din          = req_buff_din[drive_q];
      end
   end

   assign sd_rd    = (state_q == ST_ISSUE) && (op_q == OP_RD);
   assign sd_wr    = (state_q == ST_ISSUE) && (op_q == OP_WR);
   assign sd_lba   = lba_q;
   assign sd_drive = drive_q;
   assign req_err  = err_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_c1541_sd_arbiter
// Directed bench for c1541_sd_arbiter with two requesters and a short
// timeout. Inputs change 1 ns after the rising edge; outputs are sampled
// there or 1 ns later for combinational paths.
// -----------------------------------------------------------------------------
module tb_c1541_sd_arbiter;

   localparam int          NUM_REQ = 2;
   localparam int unsigned TIMEOUT = 16;

   logic                     sd_clk;
   logic                     reset;
   logic [NUM_REQ-1:0][31:0] req_lba;
   logic [NUM_REQ-1:0]       req_rd;
   logic [NUM_REQ-1:0]       req_wr;
   logic [NUM_REQ-1:0]       req_ack;
   logic [NUM_REQ-1:0]       req_err;
   logic [NUM_REQ-1:0]       req_buff_wr;
   logic [NUM_REQ-1:0][7:0]  req_buff_din;
   logic [31:0]              sd_lba;
   logic                     sd_rd;
   logic                     sd_wr;
   logic [0:0]               sd_drive;
   logic                     sd_ack;
   logic                     sd_buff_wr;
   logic [7:0]               sd_buff_din;
   logic                     busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cnt0;
   int cnt1;
   logic [0:0] g;

   c1541_sd_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .sd_clk       (sd_clk),
      .reset        (reset),
      .req_lba      (req_lba),
      .req_rd       (req_rd),
      .req_wr       (req_wr),
      .req_ack      (req_ack),
      .req_err      (req_err),
      .req_buff_wr  (req_buff_wr),
      .req_buff_din (req_buff_din),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_drive     (sd_drive),
      .sd_ack       (sd_ack),
      .sd_buff_wr   (sd_buff_wr),
      .sd_buff_din  (sd_buff_din),
      .busy         (busy)
   );

   initial sd_clk = 1'b0;
   always #5 sd_clk = ~sd_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge sd_clk);
      #1;
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (!(sd_rd || sd_wr) && n < 8) begin
         tick();
         n++;
      end
      check({tag, "_grant_seen"}, 32'(sd_rd | sd_wr), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      req_lba      = '0;
      req_rd       = '0;
      req_wr       = '0;
      req_buff_din = '0;
      sd_ack       = 1'b0;
      sd_buff_wr   = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_busy",        32'(busy),        0);
      check("rst_sd_rd",       32'(sd_rd),       0);
      check("rst_sd_wr",       32'(sd_wr),       0);
      check("rst_sd_lba",      sd_lba,           0);
      check("rst_sd_drive",    32'(sd_drive),    0);
      check("rst_req_ack",     32'(req_ack),     0);
      check("rst_req_err",     32'(req_err),     0);
      check("rst_req_buff_wr", 32'(req_buff_wr), 0);
      check("rst_sd_buff_din", 32'(sd_buff_din), 0);
      reset = 1'b0;

      // Single read from requester 1
      req_lba[1] = 32'h0000_0540;
      req_rd[1]  = 1'b1;
      tick();
      check("rd_sd_rd",    32'(sd_rd),    1);
      check("rd_sd_wr",    32'(sd_wr),    0);
      check("rd_sd_lba",   sd_lba,        32'h540);
      check("rd_sd_drive", 32'(sd_drive), 1);
      check("rd_busy",     32'(busy),     1);
      sd_ack = 1'b1;
      tick();
      check("rd_strobe_release", 32'(sd_rd),   0);
      check("rd_req_ack",        32'(req_ack), 2);
      req_rd[1] = 1'b0;
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 520; i++) begin
         sd_buff_wr = (i >= 4 && i < 516);
         #1;
         if (req_buff_wr[0]) cnt0++;
         if (req_buff_wr[1]) cnt1++;
         tick();
      end
      sd_buff_wr = 1'b0;
      check("rd_bytes_req1", 32'(cnt1), 512);
      check("rd_bytes_req0", 32'(cnt0), 0);
      sd_ack = 1'b0;
      #1;
      check("rd_busy_ack_low", 32'(busy), 1);
      tick();
      check("rd_busy_drop", 32'(busy), 0);

      // Fairness: both requesters keep asking
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      req_rd = 2'b11;
      for (int t = 0; t < 4; t++) begin
         wait_grant("fair");
         check("fair_drive", 32'(sd_drive), t % 2);
         g      = sd_drive;
         sd_ack = 1'b1;
         tick();
         req_rd[g] = 1'b0;
         repeat (3) tick();
         sd_ack = 1'b0;
         tick();
         req_rd[g] = 1'b1;
      end
      req_rd = '0;

      // Write path: rd and wr together mean write
      req_buff_din[0] = 8'hA5;
      req_buff_din[1] = 8'h3C;
      #1;
      check("wr_din_idle", 32'(sd_buff_din), 0);
      req_rd[0] = 1'b1;
      req_wr[0] = 1'b1;
      tick();
      check("wr_sd_wr",    32'(sd_wr),    1);
      check("wr_sd_rd",    32'(sd_rd),    0);
      check("wr_sd_drive", 32'(sd_drive), 0);
      sd_ack = 1'b1;
      tick();
      req_rd[0] = 1'b0;
      req_wr[0] = 1'b0;
      check("wr_din_xfer", 32'(sd_buff_din), 32'hA5);
      req_buff_din[0] = 8'h5A;
      #1;
      check("wr_din_follow", 32'(sd_buff_din), 32'h5A);
      sd_ack = 1'b0;
      tick();
      check("wr_busy_drop",   32'(busy),        0);
      check("wr_din_idle2",   32'(sd_buff_din), 0);

      // Timeout: no ack, strobe held 17 cycles, error pulse on the 18th
      req_rd[0] = 1'b1;
      tick();
      check("to_sd_rd_start", 32'(sd_rd), 1);
      repeat (16) tick();
      check("to_sd_rd_held",  32'(sd_rd),   1);
      check("to_no_err_yet",  32'(req_err), 0);
      req_rd[0] = 1'b0;
      tick();
      check("to_req_err",     32'(req_err), 1);
      check("to_sd_rd_drop",  32'(sd_rd),   0);
      check("to_busy_idle",   32'(busy),    0);
      tick();
      check("to_err_one_cycle", 32'(req_err), 0);
      // Late ack must be absorbed
      sd_ack     = 1'b1;
      sd_buff_wr = 1'b1;
      tick();
      check("to_drain_busy", 32'(busy), 1);
      for (int i = 0; i < 3; i++) begin
         check("to_drain_ack", 32'(req_ack),     0);
         check("to_drain_bwr", 32'(req_buff_wr), 0);
         tick();
      end
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      tick();
      check("to_drain_exit", 32'(busy), 0);

      // Reset in the middle of a transfer
      req_rd[1] = 1'b1;
      tick();
      check("rx_sd_drive", 32'(sd_drive), 1);
      check("rx_sd_rd",    32'(sd_rd),    1);
      sd_ack = 1'b1;
      tick();
      cnt1 = 0;
      for (int i = 0; i < 100; i++) begin
         sd_buff_wr = 1'b1;
         #1;
         if (req_buff_wr[1]) cnt1++;
         tick();
      end
      check("rx_bytes_before", 32'(cnt1), 100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rx_sd_rd_drop",   32'(sd_rd),   0);
      check("rx_req_ack_drop", 32'(req_ack), 0);
      check("rx_idle",         32'(busy),    0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rx_drain_busy", 32'(busy),        1);
         check("rx_drain_bwr",  32'(req_buff_wr), 0);
         check("rx_drain_ack",  32'(req_ack),     0);
      end
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      tick();
      check("rx_drain_exit", 32'(busy), 0);
      tick();
      check("rx_regrant_rd",    32'(sd_rd),    1);
      check("rx_regrant_drive", 32'(sd_drive), 1);
      sd_ack = 1'b1;
      tick();
      req_rd[1] = 1'b0;
      sd_ack    = 1'b0;
      tick();
      check("rx_done", 32'(busy), 0);

      // LBA is captured once at grant
      req_lba[0] = 32'h1234_5678;
      req_rd[0]  = 1'b1;
      tick();
      check("lba_grant",       sd_lba,        32'h1234_5678);
      check("lba_grant_drive", 32'(sd_drive), 0);
      req_lba[0] = 32'hDEAD_BEEF;
      tick();
      check("lba_issue_hold", sd_lba, 32'h1234_5678);
      sd_ack = 1'b1;
      tick();
      req_rd[0]  = 1'b0;
      req_lba[0] = 32'h0BAD_F00D;
      #1;
      check("lba_xfer_hold", sd_lba, 32'h1234_5678);
      sd_ack = 1'b0;
      tick();
      check("lba_done", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
